// File: rtl/avr_command_sequencer_if.sv
// Host-side op request channel for avr_command_sequencer (valid/ready plus op payload).
// The host owns the request fields; the sequencer owns op_ready.
interface avr_command_sequencer_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 op_valid;
  logic                 op_ready;
  logic [2:0]           op_code;
  logic [ADDR_BITS-1:0] op_addr;
  logic                 op_arg;

  modport master (
    output op_valid,
    output op_code,
    output op_addr,
    output op_arg,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_addr,
    input  op_arg,
    output op_ready
  );
endinterface

// File: rtl/avr_command_sequencer.sv
// AVR-side CPLD command initiator: expands host ops into timed command slots on ctrl_out/ctrl_strobe.
// Define IDLE_INSERT_EN to put a hold slot between consecutive strobed slots of one op.
module avr_command_sequencer #(
  parameter int unsigned CMD_DIV    = 4,
  parameter int unsigned ADDR_BITS  = 24,
  parameter int unsigned HOLD_SLOTS = 2
) (
  input  logic                   avr_clk,
  input  logic                   avr_reset_n,
  avr_command_sequencer_if.slave op,
  output logic [7:0]             ctrl_out,
  output logic                   ctrl_strobe,
  output logic                   busy,
  output logic                   done
);
  localparam int unsigned CycW  = $clog2(CMD_DIV);
  localparam int unsigned BitW  = $clog2(ADDR_BITS);
  localparam int unsigned HoldW = $clog2(HOLD_SLOTS + 1);

  localparam logic [CycW-1:0] CycLast = CycW'(CMD_DIV - 1);
  localparam logic [CycW-1:0] CycMid  = CycW'(CMD_DIV / 2 - 1);

  localparam logic [2:0] OpReset = 3'd1;
  localparam logic [2:0] OpLoad  = 3'd2;
  localparam logic [2:0] OpWrite = 3'd3;
  localparam logic [2:0] OpRead  = 3'd4;
  localparam logic [2:0] OpCount = 3'd5;
  localparam logic [2:0] OpSnes  = 3'd6;

  localparam logic [7:0] CmdIdle   = 8'h01;
  localparam logic [7:0] CmdSregHi = 8'h05;
  localparam logic [7:0] CmdCntHi  = 8'h0D;

  typedef enum logic [2:0] {StIdle, StLoad, StEmit, StHold, StShift, StDone} state_e;

  state_e               state_q;
  state_e               resume_q;
  logic [2:0]           op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [CycW-1:0]      cyc_q;
  logic [BitW-1:0]      bit_q;
  logic [HoldW-1:0]     hold_q;
  logic                 closing_q;
  logic                 strobed_q;

  function automatic logic [7:0] open_cmd(input logic [2:0] code, input logic arg);
    case (code)
      OpReset: return 8'h03;
      OpLoad:  return 8'h04;
      OpWrite: return 8'h0A;
      OpRead:  return 8'h08;
      OpCount: return 8'h0C;
      OpSnes:  return arg ? 8'h0F : 8'h0E;
      default: return CmdIdle;
    endcase
  endfunction

  function automatic logic [7:0] close_cmd(input logic [2:0] code);
    case (code)
      OpReset: return 8'h02;
      OpLoad:  return CmdSregHi;
      OpWrite: return 8'h0B;
      OpRead:  return 8'h09;
      OpCount: return CmdCntHi;
      default: return CmdIdle;
    endcase
  endfunction

  function automatic logic [7:0] bit_cmd(input logic b);
    return b ? 8'h07 : 8'h06;
  endfunction

  always_ff @(posedge avr_clk or negedge avr_reset_n) begin
    if (!avr_reset_n) begin
      state_q     <= StIdle;
      resume_q    <= StEmit;
      op_q        <= '0;
      addr_q      <= '0;
      cyc_q       <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      closing_q   <= 1'b0;
      strobed_q   <= 1'b0;
      ctrl_out    <= CmdIdle;
      ctrl_strobe <= 1'b0;
      op.op_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Mid-slot toggle gives the CPLD half a slot of setup and hold on ctrl_out.
      if (strobed_q && cyc_q == CycMid) ctrl_strobe <= ~ctrl_strobe;
      if (busy) cyc_q <= (cyc_q == CycLast) ? '0 : cyc_q + 1'b1;

      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (op.op_valid) begin
            op_q   <= op.op_code;
            addr_q <= op.op_addr;
            if (op.op_code == 3'd0 || op.op_code == 3'd7) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q     <= StLoad;
              ctrl_out    <= open_cmd(op.op_code, op.op_arg);
              strobed_q   <= 1'b1;
              cyc_q       <= '0;
              busy        <= 1'b1;
              op.op_ready <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
          end
        end

        // First cycle of the opening slot: set up the counters for the rest of the op.
        StLoad: begin
          closing_q <= 1'b0;
          bit_q     <= BitW'(ADDR_BITS - 1);
          hold_q    <= HoldW'(HOLD_SLOTS);
          state_q   <= StEmit;
        end

        StEmit: begin
          if (cyc_q == CycLast) begin
            if (closing_q || op_q == OpSnes) begin
              state_q     <= StDone;
              done        <= 1'b1;
              busy        <= 1'b0;
              op.op_ready <= 1'b1;
              ctrl_out    <= CmdIdle;
              strobed_q   <= 1'b0;
            end else begin
              closing_q <= 1'b1;
              case (op_q)
                OpLoad: begin
`ifdef IDLE_INSERT_EN
                  state_q   <= StHold;
                  hold_q    <= HoldW'(1);
                  resume_q  <= StShift;
                  ctrl_out  <= CmdIdle;
                  strobed_q <= 1'b0;
`else
                  state_q  <= StShift;
                  ctrl_out <= bit_cmd(addr_q[ADDR_BITS-1]);
`endif
                end
                OpCount: begin
`ifdef IDLE_INSERT_EN
                  state_q   <= StHold;
                  hold_q    <= HoldW'(1);
                  resume_q  <= StEmit;
                  ctrl_out  <= CmdIdle;
                  strobed_q <= 1'b0;
`else
                  ctrl_out <= CmdCntHi;
`endif
                end
                default: begin
                  state_q   <= StHold;
                  hold_q    <= HoldW'(HOLD_SLOTS);
                  resume_q  <= StEmit;
                  ctrl_out  <= CmdIdle;
                  strobed_q <= 1'b0;
                end
              endcase
            end
          end
        end

        StHold: begin
          if (cyc_q == CycLast) begin
            if (hold_q == HoldW'(1)) begin
              state_q   <= resume_q;
              strobed_q <= 1'b1;
              ctrl_out  <= (resume_q == StShift) ? bit_cmd(addr_q[ADDR_BITS-1]) : close_cmd(op_q);
            end else begin
              hold_q <= hold_q - 1'b1;
            end
          end
        end

        // Address goes out MSB first; addr_q shifts left so the next bit is always near the top.
        StShift: begin
          if (cyc_q == CycLast) begin
            addr_q <= addr_q << 1;
            if (bit_q == '0) begin
`ifdef IDLE_INSERT_EN
              state_q   <= StHold;
              hold_q    <= HoldW'(1);
              resume_q  <= StEmit;
              ctrl_out  <= CmdIdle;
              strobed_q <= 1'b0;
`else
              state_q  <= StEmit;
              ctrl_out <= CmdSregHi;
`endif
            end else begin
              bit_q <= bit_q - 1'b1;
`ifdef IDLE_INSERT_EN
              state_q   <= StHold;
              hold_q    <= HoldW'(1);
              resume_q  <= StShift;
              ctrl_out  <= CmdIdle;
              strobed_q <= 1'b0;
`else
              ctrl_out <= bit_cmd(addr_q[ADDR_BITS-2]);
`endif
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_avr_command_sequencer.sv
// Bench for avr_command_sequencer: vector table, reset/back-to-back sequences and random ops
// checked cycle by cycle against a slot-list reference model.
module tb_avr_command_sequencer;
  localparam int unsigned CMD_DIV    = 4;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned HOLD_SLOTS = 2;
  localparam int unsigned HALF       = CMD_DIV / 2;
`ifdef IDLE_INSERT_EN
  localparam int LoadSlots  = 2 * ADDR_BITS + 3;
  localparam int CountSlots = 3;
  localparam int Bit10Slot  = 2 + 2 * (ADDR_BITS - 1 - 10);
`else
  localparam int LoadSlots  = ADDR_BITS + 2;
  localparam int CountSlots = 2;
  localparam int Bit10Slot  = 1 + (ADDR_BITS - 1 - 10);
`endif

  logic       avr_clk = 1'b0;
  logic       avr_reset_n;
  logic [7:0] ctrl_out;
  logic       ctrl_strobe;
  logic       busy;
  logic       done;

  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_stb = 1'b0;

  avr_command_sequencer_if #(.ADDR_BITS(ADDR_BITS)) ifc ();

  avr_command_sequencer #(
    .CMD_DIV   (CMD_DIV),
    .ADDR_BITS (ADDR_BITS),
    .HOLD_SLOTS(HOLD_SLOTS)
  ) dut (
    .avr_clk    (avr_clk),
    .avr_reset_n(avr_reset_n),
    .op         (ifc.slave),
    .ctrl_out   (ctrl_out),
    .ctrl_strobe(ctrl_strobe),
    .busy       (busy),
    .done       (done)
  );

  always #5 avr_clk = ~avr_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       strobed;
    logic [7:0] cmd;
  } slot_t;

  typedef struct {
    logic [2:0]  code;
    logic [23:0] addr;
    logic        arg;
    int          slots;
    int          toggles;
    logic [7:0]  first;
    logic [7:0]  last;
  } vec_t;

  slot_t      exp_slots[$];
  logic [7:0] cap_out[$];
  logic       cap_stb[$];
  logic       cap_busy[$];
  logic       cap_rdy[$];
  int         done_at;

  function automatic void chk(input bit ok, input string what, input string got, input string want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, required %s", what, got, want);
  endfunction

  function automatic slot_t mk_s(input logic [7:0] c);
    return '{strobed: 1'b1, cmd: c};
  endfunction

  function automatic slot_t mk_h();
    return '{strobed: 1'b0, cmd: 8'h01};
  endfunction

  // Reference: the op's slot list straight from the command table.
  function automatic void build_slots(input logic [2:0] code, input logic [ADDR_BITS-1:0] addr,
                                      input logic arg);
    slot_t raw[$];
    exp_slots.delete();
    case (code)
      3'd1: begin
        raw.push_back(mk_s(8'h03));
        for (int i = 0; i < HOLD_SLOTS; i++) raw.push_back(mk_h());
        raw.push_back(mk_s(8'h02));
      end
      3'd2: begin
        raw.push_back(mk_s(8'h04));
        for (int b = ADDR_BITS - 1; b >= 0; b--) raw.push_back(mk_s(addr[b] ? 8'h07 : 8'h06));
        raw.push_back(mk_s(8'h05));
      end
      3'd3: begin
        raw.push_back(mk_s(8'h0A));
        for (int i = 0; i < HOLD_SLOTS; i++) raw.push_back(mk_h());
        raw.push_back(mk_s(8'h0B));
      end
      3'd4: begin
        raw.push_back(mk_s(8'h08));
        for (int i = 0; i < HOLD_SLOTS; i++) raw.push_back(mk_h());
        raw.push_back(mk_s(8'h09));
      end
      3'd5: begin
        raw.push_back(mk_s(8'h0C));
        raw.push_back(mk_s(8'h0D));
      end
      3'd6: raw.push_back(mk_s(arg ? 8'h0F : 8'h0E));
      default: ;
    endcase
    foreach (raw[i]) begin
`ifdef IDLE_INSERT_EN
      if (i > 0 && raw[i].strobed && raw[i-1].strobed) exp_slots.push_back(mk_h());
`endif
      exp_slots.push_back(raw[i]);
    end
  endfunction

  function automatic bit at_reset_values();
    return ctrl_out === 8'h01 && ctrl_strobe === 1'b0 && ifc.op_ready === 1'b1 &&
           busy === 1'b0 && done === 1'b0;
  endfunction

  function automatic string out_str();
    return $sformatf("ctrl_out=0x%02h strobe=%b ready=%b busy=%b done=%b",
                     ctrl_out, ctrl_strobe, ifc.op_ready, busy, done);
  endfunction

  task automatic step();
    @(posedge avr_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [ADDR_BITS-1:0] addr, input logic arg);
    int n = 0;
    ifc.op_valid = 1'b1;
    ifc.op_code  = code;
    ifc.op_addr  = addr;
    ifc.op_arg   = arg;
    while (ifc.op_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk(1'b0, "accept_wait", "op_ready low for 300 cycles", "op_ready high");
  endtask

  // Cycle 1 is the first cycle after the acceptance edge; stops on the done cycle.
  task automatic capture(input bit hold_valid);
    cap_out.delete();
    cap_stb.delete();
    cap_busy.delete();
    cap_rdy.delete();
    done_at = 0;
    step();
    if (!hold_valid) ifc.op_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      cap_out.push_back(ctrl_out);
      cap_stb.push_back(ctrl_strobe);
      cap_busy.push_back(busy);
      cap_rdy.push_back(ifc.op_ready);
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      step();
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] code,
                          input logic [ADDR_BITS-1:0] addr, input logic arg);
    int         exp_done;
    logic       lvl;
    logic       eb;
    logic [7:0] eo;
    slot_t      s;
    bit         ok_o = 1'b1;
    bit         ok_s = 1'b1;
    bit         ok_b = 1'b1;
    string      got_o = "", want_o = "", got_s = "", want_s = "", got_b = "", want_b = "";
    build_slots(code, addr, arg);
    exp_done = exp_slots.size() * CMD_DIV + 1;
    chk(done_at == exp_done, {name, " done_cycle"}, $sformatf("%0d", done_at),
        $sformatf("%0d", exp_done));
    lvl = exp_stb;
    for (int k = 1; k <= exp_done; k++) begin
      if (k < exp_done) begin
        s = exp_slots[(k - 1) / CMD_DIV];
        if (s.strobed && ((k - 1) % CMD_DIV) == HALF) lvl = ~lvl;
        eo = s.cmd;
        eb = 1'b1;
      end else begin
        eo = 8'h01;
        eb = 1'b0;
      end
      if (k > cap_out.size()) begin
        if (ok_o) begin
          ok_o = 1'b0; ok_s = 1'b0; ok_b = 1'b0;
          got_o = $sformatf("no sample at cycle %0d", k);
          got_s = got_o;
          got_b = got_o;
          want_o = $sformatf("0x%02h", eo);
          want_s = $sformatf("%b", lvl);
          want_b = $sformatf("busy=%b", eb);
        end
      end else begin
        if (ok_o && cap_out[k-1] !== eo) begin
          ok_o = 1'b0;
          got_o = $sformatf("0x%02h at cycle %0d", cap_out[k-1], k);
          want_o = $sformatf("0x%02h", eo);
        end
        if (ok_s && cap_stb[k-1] !== lvl) begin
          ok_s = 1'b0;
          got_s = $sformatf("%b at cycle %0d", cap_stb[k-1], k);
          want_s = $sformatf("%b", lvl);
        end
        if (ok_b && (cap_busy[k-1] !== eb || cap_rdy[k-1] !== ~eb)) begin
          ok_b = 1'b0;
          got_b = $sformatf("busy=%b ready=%b at cycle %0d", cap_busy[k-1], cap_rdy[k-1], k);
          want_b = $sformatf("busy=%b ready=%b", eb, ~eb);
        end
      end
    end
    chk(ok_o, {name, " ctrl_out_trace"}, got_o, want_o);
    chk(ok_s, {name, " strobe_trace"}, got_s, want_s);
    chk(ok_b, {name, " busy_ready_trace"}, got_b, want_b);
    exp_stb = lvl;
  endtask

  initial begin
    vec_t       vecs[$];
    logic       pre;
    logic       prev;
    int         tog;
    int         slots_meas;
    bit         ok;
    string      msg;
    logic [7:0] first_c;
    logic [7:0] last_c;
    logic [2:0] rcode;
    logic [23:0] raddr;
    logic       rarg;

    vecs.push_back('{3'd0, 24'h000000, 1'b0, 0, 0, 8'h01, 8'h01});
    vecs.push_back('{3'd1, 24'h000000, 1'b0, 4, 2, 8'h03, 8'h02});
    vecs.push_back('{3'd2, 24'hA50003, 1'b0, LoadSlots, 26, 8'h04, 8'h05});
    vecs.push_back('{3'd3, 24'h000000, 1'b0, 4, 2, 8'h0A, 8'h0B});
    vecs.push_back('{3'd4, 24'h000000, 1'b0, 4, 2, 8'h08, 8'h09});
    vecs.push_back('{3'd5, 24'h000000, 1'b0, CountSlots, 2, 8'h0C, 8'h0D});
    vecs.push_back('{3'd6, 24'h000000, 1'b1, 1, 1, 8'h0F, 8'h0F});
    vecs.push_back('{3'd6, 24'h000000, 1'b0, 1, 1, 8'h0E, 8'h0E});
    vecs.push_back('{3'd7, 24'h000000, 1'b1, 0, 0, 8'h01, 8'h01});
    vecs.push_back('{3'd2, 24'h5A0F81, 1'b0, LoadSlots, 26, 8'h04, 8'h05});

    avr_reset_n  = 1'b0;
    ifc.op_valid = 1'b0;
    ifc.op_code  = 3'd0;
    ifc.op_addr  = '0;
    ifc.op_arg   = 1'b0;
    repeat (3) step();
    chk(at_reset_values(), "in_reset_outputs", out_str(),
        "ctrl_out=0x01 strobe=0 ready=1 busy=0 done=0");
    avr_reset_n = 1'b1;

    ok = 1'b1;
    msg = "";
    for (int k = 0; k < 20; k++) begin
      step();
      if (ok && !at_reset_values()) begin
        ok = 1'b0;
        msg = $sformatf("%s at idle cycle %0d", out_str(), k);
      end
    end
    chk(ok, "idle_20_cycles", msg, "ctrl_out=0x01 strobe=0 ready=1 busy=0 done=0");

    foreach (vecs[i]) begin
      pre = exp_stb;
      issue(vecs[i].code, vecs[i].addr, vecs[i].arg);
      capture(1'b0);
      check_op($sformatf("vec%0d_op%0d", i, vecs[i].code), vecs[i].code, vecs[i].addr,
               vecs[i].arg);
      slots_meas = (done_at - 1) / int'(CMD_DIV);
      tog = 0;
      prev = pre;
      foreach (cap_stb[j]) begin
        if (cap_stb[j] !== prev) tog++;
        prev = cap_stb[j];
      end
      chk(slots_meas == vecs[i].slots, $sformatf("vec%0d slot_count", i),
          $sformatf("%0d", slots_meas), $sformatf("%0d", vecs[i].slots));
      chk(tog == vecs[i].toggles, $sformatf("vec%0d toggle_count", i), $sformatf("%0d", tog),
          $sformatf("%0d", vecs[i].toggles));
      if (vecs[i].slots > 0) begin
        first_c = (cap_out.size() > 0) ? cap_out[0] : 8'hxx;
        last_c  = (done_at >= 2) ? cap_out[done_at-2] : 8'hxx;
        chk(first_c === vecs[i].first, $sformatf("vec%0d first_cmd", i),
            $sformatf("0x%02h", first_c), $sformatf("0x%02h", vecs[i].first));
        chk(last_c === vecs[i].last, $sformatf("vec%0d last_cmd", i),
            $sformatf("0x%02h", last_c), $sformatf("0x%02h", vecs[i].last));
      end
    end

    // Back-to-back: op_valid never drops, second op must start right after the done cycle.
    issue(3'd5, '0, 1'b0);
    capture(1'b1);
    check_op("b2b_counter", 3'd5, '0, 1'b0);
    ifc.op_code = 3'd6;
    ifc.op_arg  = 1'b1;
    capture(1'b0);
    check_op("b2b_snes", 3'd6, '0, 1'b1);

    // Reset in the middle of LOAD_ADDR while address bit 10 is on the wire.
    issue(3'd2, 24'hA50003, 1'b0);
    step();
    ifc.op_valid = 1'b0;
    build_slots(3'd2, 24'hA50003, 1'b0);
    for (int k = 1; k < Bit10Slot * int'(CMD_DIV) + 2; k++) step();
    chk(ctrl_out === exp_slots[Bit10Slot].cmd, "mid_load_bit10_cmd",
        $sformatf("0x%02h", ctrl_out), $sformatf("0x%02h", exp_slots[Bit10Slot].cmd));
    #2 avr_reset_n = 1'b0;
    #1;
    chk(at_reset_values(), "mid_op_reset_outputs", out_str(),
        "ctrl_out=0x01 strobe=0 ready=1 busy=0 done=0");
    step();
    step();
    avr_reset_n = 1'b1;
    exp_stb = 1'b0;
    step();
    issue(3'd2, 24'hA50003, 1'b0);
    capture(1'b0);
    check_op("load_after_reset", 3'd2, 24'hA50003, 1'b0);

    for (int r = 0; r < 25; r++) begin
      rcode = 3'($urandom_range(0, 7));
      raddr = 24'($urandom);
      rarg  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      issue(rcode, raddr, rarg);
      capture(1'b0);
      check_op($sformatf("rand%0d_op%0d", r, rcode), rcode, raddr, rarg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
